// File: rtl/digit_serial_sub_32bit_pkg.sv
// Shared constants for the digit-serial subtractor: FSM encoding, default
// operand/digit widths and the digit-counter width helper.
package digit_serial_sub_32bit_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DIGIT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-digit configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = width / digit;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH, DEF_DIGIT);

endpackage

// File: rtl/digit_serial_sub_32bit_slice.sv
// DIGIT-bit combinational ripple-borrow subtractor: diff = A_in - B_in - B_in_borrow.
// Zero latency; no handshake, purely combinational.
module sub_slice_4bit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] A_in,
   input  logic [DIGIT-1:0] B_in,
   input  logic             B_in_borrow,
   output logic [DIGIT-1:0] diff,
   output logic             B_out
);

   // The borrow ripples through a local variable so no vector feeds back on itself.
   always_comb begin
      logic br;
      br   = B_in_borrow;
      diff = '0;
      for (int i = 0; i < DIGIT; i++) begin
         diff[i] = A_in[i] ^ B_in[i] ^ br;
         br      = (~A_in[i] & B_in[i]) | (~(A_in[i] ^ B_in[i]) & br);
      end
      B_out = br;
   end

endmodule

// File: rtl/digit_serial_sub_32bit.sv
// Digit-serial A - B - Bor_in, DIGIT bits per cycle; result valid WIDTH/DIGIT cycles after accept.
// Holds result in DONE until out_ready; in_ready only in IDLE. SUB_FLAGS_EN adds zero_flag/neg_flag.
module digit_serial_sub_32bit
   import digit_serial_sub_32bit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             Bor_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             Bor_out,
   output logic             ovf
`ifdef SUB_FLAGS_EN
   ,
   output logic             zero_flag,
   output logic             neg_flag
`endif
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             bor_q, bor_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bor_out_q, bor_out_d;
   logic             ovf_q, ovf_d;
`ifdef SUB_FLAGS_EN
   logic             zf_q, zf_d;
   logic             nf_q, nf_d;
`endif

   logic [DIGIT-1:0] slice_diff;
   logic             slice_bor;
   logic [WIDTH-1:0] shifted_diff;

   sub_slice_4bit #(
      .DIGIT (DIGIT)
   ) u_slice (
      .A_in        (a_q[DIGIT-1:0]),
      .B_in        (b_q[DIGIT-1:0]),
      .B_in_borrow (bor_q),
      .diff        (slice_diff),
      .B_out       (slice_bor)
   );

   // New digit enters at the top; after NDIG shifts the LSB digit has reached bit 0.
   assign shifted_diff = {slice_diff, sh_q[WIDTH-1:DIGIT]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      sh_d      = sh_q;
      bor_d     = bor_q;
      amsb_d    = amsb_q;
      bmsb_d    = bmsb_q;
      diff_d    = diff_q;
      bor_out_d = bor_out_q;
      ovf_d     = ovf_q;
`ifdef SUB_FLAGS_EN
      zf_d      = zf_q;
      nf_d      = nf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A_in;
               b_d     = B_in;
               bor_d   = Bor_in;
               amsb_d  = A_in[WIDTH-1];
               bmsb_d  = B_in[WIDTH-1];
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            sh_d  = shifted_diff;
            bor_d = slice_bor;
            cnt_d = cnt_q + CW'(1);
            // Result registers load only here so a partial diff is never visible.
            if (cnt_q == LAST_CNT) begin
               state_d   = DONE;
               diff_d    = shifted_diff;
               bor_out_d = slice_bor;
               ovf_d     = (amsb_q != bmsb_q) && (shifted_diff[WIDTH-1] != amsb_q);
`ifdef SUB_FLAGS_EN
               zf_d      = (shifted_diff == '0);
               nf_d      = shifted_diff[WIDTH-1];
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sh_q      <= '0;
         bor_q     <= 1'b0;
         amsb_q    <= 1'b0;
         bmsb_q    <= 1'b0;
         diff_q    <= '0;
         bor_out_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sh_q      <= sh_d;
         bor_q     <= bor_d;
         amsb_q    <= amsb_d;
         bmsb_q    <= bmsb_d;
         diff_q    <= diff_d;
         bor_out_q <= bor_out_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef SUB_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zf_q <= 1'b0;
         nf_q <= 1'b0;
      end else begin
         zf_q <= zf_d;
         nf_q <= nf_d;
      end
   end

   assign zero_flag = zf_q;
   assign neg_flag  = nf_q;
`endif

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign Bor_out   = bor_out_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_sub_32bit.sv
// Directed bench for digit_serial_sub_32bit: reset, latency, borrow/overflow corners,
// backpressure, and a back-to-back random run against an arithmetic reference.
module tb_digit_serial_sub_32bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A_in;
   logic [31:0] B_in;
   logic        Bor_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        Bor_out;
   logic        ovf;
`ifdef SUB_FLAGS_EN
   logic        zero_flag;
   logic        neg_flag;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   digit_serial_sub_32bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A_in      (A_in),
      .B_in      (B_in),
      .Bor_in    (Bor_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .Bor_out   (Bor_out),
      .ovf       (ovf)
`ifdef SUB_FLAGS_EN
      ,
      .zero_flag (zero_flag),
      .neg_flag  (neg_flag)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   // One full transaction with a one-cycle result handshake.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic [31:0] exp_d, input logic exp_b,
                        input logic exp_o);
      int n;
      A_in = a; B_in = b; Bor_in = bin; in_valid = 1'b1; out_ready = 1'b0;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0; A_in = $urandom; B_in = $urandom; Bor_in = 1'b1;
      check({tag, "_busy"}, 64'(in_ready), 64'd0);
      wait_done(n);
      check({tag, "_latency"}, 64'(n), 64'd8);
      check({tag, "_diff"}, 64'(diff), 64'(exp_d));
      check({tag, "_bor"}, 64'(Bor_out), 64'(exp_b));
      check({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
`ifdef SUB_FLAGS_EN
      check({tag, "_zero"}, 64'(zero_flag), 64'(exp_d == 32'd0));
      check({tag, "_neg"}, 64'(neg_flag), 64'(exp_d[31]));
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_released"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int n;
      int seen;
      int t0;
      logic [31:0] ra, rb;
      logic        rbin;
      logic [32:0] r;
      logic        r_ovf;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A_in = '0; B_in = '0; Bor_in = 1'b0;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_bor", 64'(Bor_out), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      step();

      do_op("basic", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0);

      // Abort an operation three cycles into RUN.
      A_in = 32'h1234_5678; B_in = 32'd1; Bor_in = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      #2 rst = 1'b1;
      #2;
      check("abort_diff", 64'(diff), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen = 1;
      end
      check("abort_no_result", 64'(seen), 64'd0);

      do_op("underflow", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      do_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
      do_op("neg_small", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
      do_op("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h0246_8ACE, 1'b0, 1'b0);
      do_op("zero", 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1, 32'd0, 1'b0, 1'b0);

      // Backpressure: result held while out_ready is low; new operands ignored.
      A_in = 32'd100; B_in = 32'd1; Bor_in = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_done(n);
      check("bp_latency", 64'(n), 64'd8);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; A_in = $urandom; B_in = $urandom;
         step();
         check("bp_diff_hold", 64'(diff), 64'd99);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      A_in = 32'd7; B_in = 32'd2; Bor_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release_idle", 64'(in_ready), 64'd1);
      check("bp_release_valid", 64'(out_valid), 64'd0);
      step();
      in_valid = 1'b0;
      check("bp_accept", 64'(in_ready), 64'd0);
      wait_done(n);
      check("bp_next_latency", 64'(n), 64'd8);
      check("bp_next_diff", 64'(diff), 64'd5);
      out_ready = 1'b1;
      step();

      // Back-to-back random operands with in_valid and out_ready held high.
      in_valid = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
         A_in = ra; B_in = rb; Bor_in = rbin;
         r = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
         r_ovf = (ra[31] != rb[31]) && (r[31] != ra[31]);
         step();
         A_in = $urandom; B_in = $urandom;
         wait_done(n);
         check("rand_result", {30'd0, n[1:0] == 2'd0 && n == 8, diff, Bor_out, ovf},
               {30'd0, 1'b1, r[31:0], r[32], r_ovf});
         step();
      end
      check("rand_throughput", 64'(cyc - t0), 64'd10000);
      in_valid = 1'b0; out_ready = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_serial_sub_32bit.md
Name: digit_serial_sub_32bit

Overview:
- Multi-cycle 32-bit unsigned/two's-complement subtractor: DIFF = A - B - borrow_in.
- Serves as the complement of the team's 32-bit ripple-carry adder: A and B are consumed DIGIT bits per cycle through one small ripple-borrow slice, trading latency for area.
- Uses a valid/ready handshake on both input and output, so it can sit in the ALU datapath next to the adder and stall cleanly.

Parameters:
- WIDTH, 32, operand width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; the latency is WIDTH/DIGIT cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A_in  input  WIDTH  minuend.
- B_in  input  WIDTH  subtrahend.
- Bor_in  input  1  borrow-in.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  A_in - B_in - Bor_in, modulo 2^WIDTH.
- Bor_out  output  1  unsigned borrow: 1 iff A_in < B_in + Bor_in.
- ovf  output  1  signed overflow: (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]).

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE and the digit counter clears.
  - diff = 0, Bor_out = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 once rst is deasserted.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready = 1. When in_valid is high on an edge, capture A, B and Bor_in into shift registers, clear the counter, go to RUN.
  - RUN: in_ready = 0. Each edge:
    - the slice computes the low DIGIT bits of the A and B registers minus the running borrow;
    - the result digit is shifted into the top of the diff register, and the A and B registers shift right by DIGIT;
    - the running borrow is updated and the counter increments.
    - On the edge where the counter equals WIDTH/DIGIT-1, go to DONE.
  - DONE: out_valid = 1. diff, Bor_out and ovf are stable and registered. When out_ready is high on an edge, go to IDLE and clear out_valid.
- Latency and throughput:
  - out_valid rises exactly WIDTH/DIGIT cycles after the accepting edge (8 at defaults).
  - A transfer completes on the edge where out_valid and out_ready are both high.
  - No overlap: a new operand is accepted earliest on the edge after the result handshake, giving WIDTH/DIGIT+2 cycles per operation minimum.
- Operand capture:
  - Operand MSBs are captured separately at accept for the ovf computation.
  - A_in and B_in are don't-care after the accepting edge.
- Borrow rules:
  - Bor_out is the slice borrow-out of the final digit.
  - ovf is computed combinationally from the captured MSBs and the final diff MSB, then registered on entry to DONE.
- Boundary conditions:
  - in_valid high outside IDLE is ignored; it is not queued.
  - out_ready high outside DONE is ignored.
  - out_ready held permanently high: DONE lasts exactly one cycle.
  - 0 - 0 - 1 gives diff = 0xFFFFFFFF, Bor_out = 1.
  - 0x80000000 - 1 gives ovf = 1.

Optional Feature:
- Macro: SUB_FLAGS_EN.
- Defined: two extra output ports, each 1 bit and registered alongside diff:
  - zero_flag = (diff == 0);
  - neg_flag = diff[MSB].
  - Both reset to 0 and update only on entry to DONE.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include:
  - state encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - default WIDTH/DIGIT constants;
  - counter width = clog2(WIDTH/DIGIT).
- One sub-module: sub_slice_4bit, a combinational DIGIT-bit ripple-borrow subtractor (diff, B_out, A_in, B_in, B_in_borrow) built from full-subtractor equations. It is instantiated once in the top block.

Test Plan:
- Reset mid-RUN: assert rst 3 cycles after accepting 0x12345678 - 1 -> out_valid never rises, diff = 0, state returns to IDLE with in_ready = 1.
- Basic subtract: A = 5, B = 3, Bor_in = 0, accepted at edge 0 -> out_valid rises after edge 8 with diff = 2, Bor_out = 0, ovf = 0.
- Unsigned underflow: A = 0, B = 0, Bor_in = 1 -> diff = 0xFFFFFFFF, Bor_out = 1, ovf = 0 (with SUB_FLAGS_EN: neg_flag = 1, zero_flag = 0).
- Signed overflow: A = 0x80000000, B = 1 -> diff = 0x7FFFFFFF, ovf = 1, Bor_out = 0; and A = 0x7FFFFFFF, B = 0xFFFFFFFF -> diff = 0x80000000, ovf = 1, Bor_out = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE, pulsing in_valid with new operands -> diff stays stable, in_ready = 0, the new operands are ignored; the first accept happens the edge after out_ready goes high.
- Randomised back-to-back: 1000 random operand pairs with out_ready = 1 -> every result matches a reference model of A - B - Bor_in (diff, Bor_out, ovf), with a throughput of 10 cycles per operation.
